// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing, renderer colours and the coordinate type.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int VGA_DIV         = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 515;

  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] GRAY  = 12'h888;
  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] GREEN = 12'h0F0;

endpackage

// File: rtl/vga_pix_div.sv
// Board-clock to pixel-rate divider; tick_nxt_o is the value pix_tick_o takes at the next edge.
module vga_pix_div #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_nxt_o,
  output logic pix_tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // With DIV=1 the counter sits at 0 == LAST, so the tick stays high.
  always_comb begin
    cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_nxt_o = (cnt_d == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_nxt_o;
    end
  end

  assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, syncs, bright and frame strobes, all aligned to the counters.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_count output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int DIV         = VGA_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       vblank_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t HS     = coord_t'(H_SYNC);
  localparam coord_t VS     = coord_t'(V_SYNC);
  localparam coord_t HA0    = coord_t'(H_ACT_START);
  localparam coord_t HA1    = coord_t'(H_ACT_END);
  localparam coord_t VA0    = coord_t'(V_ACT_START);
  localparam coord_t VA1    = coord_t'(V_ACT_END);

  logic   tick_nxt;
  coord_t h_q, h_d, v_q, v_d;
  logic   hs_q, vs_q, br_q, fs_q, vb_q;
  logic   fs_d, vb_d;

  vga_pix_div #(.DIV(DIV)) u_div (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .tick_nxt_o (tick_nxt),
    .pix_tick_o (pix_tick)
  );

  // Counters advance on the same edge that registers pix_tick, so they line up with it.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick_nxt) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
    end
    fs_d = tick_nxt && (h_d == '0) && (v_d == '0);
    vb_d = tick_nxt && (h_d == '0) && (v_d == VA1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      br_q <= 1'b0;
      fs_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= (h_d >= HS);
      vs_q <= (v_d >= VS);
      br_q <= (h_d >= HA0) && (h_d < HA1) && (v_d >= VA0) && (v_d < VA1);
      fs_q <= fs_d;
      vb_q <= vb_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_q;

  always_ff @(posedge Clk) begin
    if (!Reset)    fc_q <= '0;
    else if (fs_d) fc_q <= fc_q + 8'd1;
  end

  assign frame_count = fc_q;
`endif

  assign hCount       = h_q;
  assign vCount       = v_q;
  assign hSync        = hs_q;
  assign vSync        = vs_q;
  assign bright       = br_q;
  assign frame_start  = fs_q;
  assign vblank_start = vb_q;

endmodule
